pwm_freq_meter: RTL and testbench

Measures an incoming square/PWM waveform: period and high time in `clk` cycles, plus a frequency-in-tolerance flag and stuck-level detection. It is the receive-side counterpart of the block's clock-divider outputs and sits on the board-loopback and monitoring path. With defaults and a 100 MHz `clk`, it checks a 100 kHz (1000-cycle) waveform.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_sync_edge.sv | 31 +++
 rtl/pwm_freq_meter.sv | 116 +++++++++++
 tb/tb_pwm_freq_meter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM capture/measurement blocks.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W           = 16;
  localparam int unsigned PWM_NOMINAL_100K    = 1000;
  localparam int unsigned PWM_TOL_DEFAULT     = 10;
  localparam int unsigned PWM_TIMEOUT_DEFAULT = 4000;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } meter_state_t;

  // Lower in-band limit, clamped at zero when the tolerance exceeds the nominal.
  function automatic int unsigned lower_limit(input int unsigned nominal,
                                              input int unsigned tol);
    return (nominal < tol) ? 32'd0 : nominal - tol;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus history flop; flags single-cycle rising/falling edges.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level  = s2;
  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

endmodule

// File: rtl/pwm_freq_meter.sv
// Measures period/high time of an asynchronous PWM input, flags in-band
// frequency and detects a stuck input level after a rise timeout.
module pwm_freq_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W          = PWM_CNT_W,
  parameter int unsigned NOMINAL_PERIOD = PWM_NOMINAL_100K,
  parameter int unsigned TOLERANCE      = PWM_TOL_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = PWM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(lower_limit(NOMINAL_PERIOD, TOLERANCE));
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             level;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;
  logic             fall_seen;
  logic             in_band_c;
  meter_state_t     state;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (pwm_in),
    .level  (level),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign in_band_c = (cnt >= LO_LIM) && (cnt <= HI_LIM);

  // Cycle counter since the last rise; parks at the timeout value while stuck.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hi_lat    <= '0;
      fall_seen <= 1'b0;
    end else begin
      if (rise_c) begin
        cnt       <= CNT_ONE;
        fall_seen <= 1'b0;
      end else if (cnt != TIMEOUT) begin
        cnt <= cnt + CNT_ONE;
      end
      if (fall_c) begin
        hi_lat    <= cnt;
        fall_seen <= 1'b1;
      end
    end
  end

  // Measurement state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARMED;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ARMED: begin
          if (rise_c) begin
            state <= MEASURE;
          end else if (cnt == TIMEOUT) begin
            state   <= STUCK;
            freq_ok <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            period     <= cnt;
            high_time  <= fall_seen ? hi_lat : cnt;
            freq_ok    <= in_band_c;
            meas_valid <= 1'b1;
          end else if (cnt == TIMEOUT) begin
            state   <= STUCK;
            freq_ok <= 1'b0;
          end
        end
        STUCK: begin
          freq_ok <= 1'b0;
          // Recovery rise only restarts the count; its partial period is discarded.
          if (rise_c) begin
            state      <= MEASURE;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
          end else begin
            stuck_high <= level;
            stuck_low  <= ~level;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_freq_meter.sv
// Scoreboard bench for pwm_freq_meter: a sample-level reference model predicts
// measurements and stuck flags; a negedge monitor compares against the DUT.
module tb_pwm_freq_meter;

  localparam int W    = 16;
  localparam int NOM  = 1000;
  localparam int TOL  = 10;
  localparam int TMO  = 4000;
  localparam int NMAX = 100000;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         freq_ok;
  logic         stuck_high;
  logic         stuck_low;

  pwm_freq_meter #(
    .CNT_W          (W),
    .NOMINAL_PERIOD (NOM),
    .TOLERANCE      (TOL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int per;
    int hi;
    int ok;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rst = 0;
  int fall_at  = -1;
  bit r_real   = 1'b0;
  bit samp[NMAX];
  bit rsts[NMAX];
  int r_at[NMAX];
  bit m_prev;
  int m_gap;
  int rr;
  bit exp_sh;
  bit exp_sl;
  bit exp_st;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: works on the sampled input sequence, edge index by edge index.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < NMAX) begin
      samp[cyc] = pwm_in;
      rsts[cyc] = rst;
      if (rst) begin
        last_rst  = cyc;
        r_real    = 1'b0;
        fall_at   = -1;
        r_at[cyc] = cyc - 1;
        while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
      end else begin
        m_prev    = (cyc - 1 == last_rst) ? 1'b0 : samp[cyc-1];
        r_at[cyc] = r_at[cyc-1];
        if (samp[cyc] && !m_prev) begin
          m_gap = cyc - r_at[cyc-1];
          if (r_real && m_gap <= TMO) begin
            e.due = cyc + 2;
            e.per = m_gap;
            e.hi  = (fall_at >= 0) ? fall_at - r_at[cyc-1] : m_gap;
            e.ok  = (m_gap >= NOM - TOL && m_gap <= NOM + TOL) ? 1 : 0;
            q.push_back(e);
          end
          r_at[cyc] = cyc;
          r_real    = 1'b1;
          fall_at   = -1;
        end else if (!samp[cyc] && m_prev) begin
          fall_at = cyc;
        end
      end
    end
  end

  // Monitor: compares DUT outputs after each active edge.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NMAX) begin
      if (rsts[cyc]) begin
        check("reset_period", int'(period), 0);
        check("reset_high_time", int'(high_time), 0);
        check("reset_flags", int'({meas_valid, freq_ok, stuck_high, stuck_low}), 0);
      end else begin
        exp_sh = 1'b0;
        exp_sl = 1'b0;
        exp_st = 1'b0;
        if (cyc >= 3 && last_rst < cyc - 2) begin
          rr     = r_at[cyc-2];
          exp_st = (cyc >= rr + TMO + 2);
          if (cyc >= rr + TMO + 3) begin
            exp_sh = samp[cyc-2];
            exp_sl = !samp[cyc-2];
          end
        end
        check("stuck_flags", int'({stuck_high, stuck_low}), int'({exp_sh, exp_sl}));
        if (exp_st) check("freq_ok_stuck", int'(freq_ok), 0);
        if (meas_valid) begin
          if (q.size() == 0) begin
            check("meas_unexpected", int'(meas_valid), 0);
          end else begin
            e = q.pop_front();
            check("meas_time", cyc, e.due);
            check("period", int'(period), e.per);
            check("high_time", int'(high_time), e.hi);
            check("freq_ok", int'(freq_ok), e.ok);
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          check("meas_missing", int'(meas_valid), 1);
        end
      end
    end
  end

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p;
    int h;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Nominal, then shape and band-edge cases.
    wave(500, 500, 5);
    wave(300, 700, 3);
    wave(505, 505, 3);
    wave(506, 506, 3);

    // Random periods, every fourth one close to the band edges.
    for (int i = 0; i < 15; i++) begin
      if (i % 4 == 0) begin
        p = int'($urandom_range(988, 1012));
        h = int'($urandom_range(1, p - 1));
        wave(h, p - h, 1);
      end else begin
        wave(int'($urandom_range(1, 1100)), int'($urandom_range(1, 1100)), 1);
      end
    end

    // Stuck low, then recovery.
    drive(1'b1, 500);
    drive(1'b0, 4500);
    wave(500, 500, 3);

    // Stuck high, fall into stuck low, then recovery.
    drive(1'b1, 5000);
    drive(1'b0, 20);
    wave(500, 500, 3);

    // Reset mid low phase and mid high phase.
    drive(1'b1, 500);
    drive(1'b0, 250);
    pulse_rst();
    drive(1'b0, 249);
    wave(500, 500, 3);
    drive(1'b1, 250);
    pulse_rst();
    drive(1'b1, 249);
    drive(1'b0, 500);
    wave(500, 500, 2);

    // Rise coinciding with the timeout, then one cycle past it.
    wave(2000, 2000, 3);
    wave(2000, 2001, 1);
    wave(2000, 2000, 1);
    wave(500, 500, 2);

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
